// File: rtl/vd_ctrl.sv
// Viterbi decoder frame controller: sequences path-metric init, ACS symbol intake,
// windowed traceback launches and the frame-final flush traceback.
//   state  | meaning
//   IDLE   | waiting for frame_start_i
//   INIT   | pulse pm_init_o, clear write address and window count
//   RUN    | accepting symbols into survivor memory
//   TB_REQ | window full; launch traceback once the TBU is free
//   FLUSH  | last symbol seen; launch the final traceback once the TBU is free
//   DRAIN  | waiting for the final traceback to complete
//   DONE   | one-cycle frame_done_o pulse
module vd_ctrl #(
    parameter int TBL = 15,
    parameter int AW  = 5,
    parameter int CW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start_i,
    input  logic          sym_valid_i,
    input  logic          sym_last_i,
    output logic          sym_ready_o,
    output logic          pm_init_o,
    output logic          acs_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          tb_start_o,
    output logic          tb_flush_o,
    output logic [AW-1:0] tb_addr_o,
    output logic [CW-1:0] tb_len_o,
    input  logic          tbu_busy_i,
    input  logic          tbu_done_i,
    output logic          frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TB_REQ,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] WR_LAST = AW'(2 * TBL - 1);
    localparam logic [CW-1:0] TBL_C   = CW'(TBL);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] tb_addr_q, tb_addr_d;
    logic [CW-1:0] tb_len_q, tb_len_d;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] wr_addr_inc;

    assign cnt_inc     = cnt_q + 1'b1;
    assign wr_addr_inc = (wr_addr_q == WR_LAST) ? '0 : wr_addr_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            tb_addr_q <= '0;
            tb_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            tb_addr_q <= tb_addr_d;
            tb_len_q  <= tb_len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        cnt_d        = cnt_q;
        tb_addr_d    = tb_addr_q;
        tb_len_d     = tb_len_q;
        sym_ready_o  = 1'b0;
        pm_init_o    = 1'b0;
        acs_en_o     = 1'b0;
        tb_start_o   = 1'b0;
        tb_flush_o   = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) state_d = S_INIT;
            end
            S_INIT: begin
                pm_init_o = 1'b1;
                wr_addr_d = '0;
                cnt_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                sym_ready_o = 1'b1;
                acs_en_o    = sym_valid_i && sym_ready_o;
                if (acs_en_o) begin
                    wr_addr_d = wr_addr_inc;
                    cnt_d     = cnt_inc;
                    tb_addr_d = wr_addr_q;
                    tb_len_d  = cnt_inc;
                    // A last symbol that also fills the window goes straight to the flush.
                    if (sym_last_i)            state_d = S_FLUSH;
                    else if (cnt_inc == TBL_C) state_d = S_TB_REQ;
                end
            end
            S_TB_REQ: begin
                if (!tbu_busy_i) begin
                    tb_start_o = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_FLUSH: begin
                if (!tbu_busy_i) begin
                    tb_start_o = 1'b1;
                    tb_flush_o = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tbu_done_i) state_d = S_DONE;
            end
            S_DONE: begin
                frame_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_addr_o = wr_addr_q;
    assign tb_addr_o = tb_addr_q;
    assign tb_len_o  = tb_len_q;

endmodule

// File: tb/tb_vd_ctrl.sv
// Self-checking bench for vd_ctrl: reference vector table, directed window/flush/reset
// sequences, then randomized traffic against a frame-level behavioural model.
module tb_vd_ctrl;
    localparam int TBL = 15;
    localparam int AW  = 5;
    localparam int CW  = 5;
    localparam int DEPTH = 2 * TBL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start, sym_valid, sym_last, tbu_busy, tbu_done;
    logic          sym_ready, pm_init, acs_en, tb_start, tb_flush, frame_done;
    logic [AW-1:0] wr_addr, tb_addr;
    logic [CW-1:0] tb_len;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vd_ctrl #(.TBL(TBL), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start_i(frame_start), .sym_valid_i(sym_valid), .sym_last_i(sym_last),
        .sym_ready_o(sym_ready), .pm_init_o(pm_init), .acs_en_o(acs_en),
        .wr_addr_o(wr_addr), .tb_start_o(tb_start), .tb_flush_o(tb_flush),
        .tb_addr_o(tb_addr), .tb_len_o(tb_len),
        .tbu_busy_i(tbu_busy), .tbu_done_i(tbu_done), .frame_done_o(frame_done)
    );

    typedef struct {
        logic rdy, pm, acs, tbs, fl, fd;
        int   wr, tba, tbl;
    } exp_t;

    typedef struct {
        logic st, v, l, b, d;
        exp_t e;
    } vec_t;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".sym_ready"},  int'(sym_ready),  int'(e.rdy));
        chk({tag, ".pm_init"},    int'(pm_init),    int'(e.pm));
        chk({tag, ".acs_en"},     int'(acs_en),     int'(e.acs));
        chk({tag, ".tb_start"},   int'(tb_start),   int'(e.tbs));
        chk({tag, ".tb_flush"},   int'(tb_flush),   int'(e.fl));
        chk({tag, ".frame_done"}, int'(frame_done), int'(e.fd));
        chk({tag, ".wr_addr"},    int'(wr_addr),    e.wr);
        chk({tag, ".tb_addr"},    int'(tb_addr),    e.tba);
        chk({tag, ".tb_len"},     int'(tb_len),     e.tbl);
    endtask

    task automatic set_in(input logic st, input logic v, input logic l, input logic b, input logic d);
        frame_start = st; sym_valid = v; sym_last = l; tbu_busy = b; tbu_done = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, v, l, b, d, rdy, pm, acs, tbs, fl, fd,
                                input int wr, tba, tbl);
        vec_t r;
        r.st = st; r.v = v; r.l = l; r.b = b; r.d = d;
        r.e.rdy = rdy; r.e.pm = pm; r.e.acs = acs; r.e.tbs = tbs; r.e.fl = fl; r.e.fd = fd;
        r.e.wr = wr; r.e.tba = tba; r.e.tbl = tbl;
        return r;
    endfunction

    // Behavioural reference: symbol totals and window fill tracked as plain integers.
    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_WIN = 3, P_FIN = 4, P_WAIT = 5, P_END = 6;
    int m_ph, m_acc, m_win, m_tba, m_tbl;

    task automatic m_reset();
        m_ph = P_IDLE; m_acc = 0; m_win = 0; m_tba = 0; m_tbl = 0;
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.rdy = (m_ph == P_RUN);
        e.pm  = (m_ph == P_INIT);
        e.acs = e.rdy && sym_valid;
        e.tbs = (m_ph == P_WIN || m_ph == P_FIN) && !tbu_busy;
        e.fl  = (m_ph == P_FIN) && !tbu_busy;
        e.fd  = (m_ph == P_END);
        e.wr  = m_acc % DEPTH;
        e.tba = m_tba;
        e.tbl = m_tbl;
        return e;
    endfunction

    task automatic m_clock(input logic st, v, l, b, d);
        case (m_ph)
            P_IDLE: if (st) m_ph = P_INIT;
            P_INIT: begin m_acc = 0; m_win = 0; m_ph = P_RUN; end
            P_RUN: if (v) begin
                m_tba = m_acc % DEPTH;
                m_acc++;
                m_win++;
                m_tbl = m_win;
                if (l) m_ph = P_FIN;
                else if (m_win == TBL) m_ph = P_WIN;
            end
            P_WIN: if (!b) begin m_win = 0; m_ph = P_RUN; end
            P_FIN: if (!b) begin m_win = 0; m_ph = P_WAIT; end
            P_WAIT: if (d) m_ph = P_END;
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic start_frame(input string tag);
        set_in(1, 0, 0, 0, 0); #2; tick();
        set_in(0, 0, 0, 0, 0); #2;
        chk({tag, ".pm_init"}, int'(pm_init), 1);
        tick();
    endtask

    vec_t vt[14];
    exp_t e0;

    initial begin
        vt[0]  = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
        vt[1]  = mk(1,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
        vt[2]  = mk(0,1,0,0,0, 0,1,0,0,0,0, 0,0,0);
        vt[3]  = mk(0,1,0,0,0, 1,0,1,0,0,0, 0,0,0);
        vt[4]  = mk(0,1,0,0,0, 1,0,1,0,0,0, 1,0,1);
        vt[5]  = mk(0,0,0,0,1, 1,0,0,0,0,0, 2,1,2);
        vt[6]  = mk(0,1,1,0,0, 1,0,1,0,0,0, 2,1,2);
        vt[7]  = mk(0,0,0,1,0, 0,0,0,0,0,0, 3,2,3);
        vt[8]  = mk(0,0,0,0,0, 0,0,0,1,1,0, 3,2,3);
        vt[9]  = mk(1,1,0,0,0, 0,0,0,0,0,0, 3,2,3);
        vt[10] = mk(0,0,0,0,1, 0,0,0,0,0,0, 3,2,3);
        vt[11] = mk(0,0,0,0,0, 0,0,0,0,0,1, 3,2,3);
        vt[12] = mk(0,0,0,0,1, 0,0,0,0,0,0, 3,2,3);
        vt[13] = mk(0,0,0,0,0, 0,0,0,0,0,0, 3,2,3);

        e0 = '{rdy: 0, pm: 0, acs: 0, tbs: 0, fl: 0, fd: 0, wr: 0, tba: 0, tbl: 0};

        rst_n = 1'b0;
        set_in(0, 1, 0, 0, 1);
        tick(); tick();
        chk_out("reset", e0);
        rst_n = 1'b1;

        // Reference vector table: short frame, flush stall, ignored inputs.
        for (int i = 0; i < 14; i++) begin
            set_in(vt[i].st, vt[i].v, vt[i].l, vt[i].b, vt[i].d);
            #2;
            chk_out($sformatf("vec%0d", i), vt[i].e);
            tick();
        end

        // 40-symbol frame: free window, stalled window, flush of the remainder.
        start_frame("a");
        #2; chk("a.ready_after_init", int'(sym_ready), 1);
        for (int k = 0; k < TBL; k++) begin
            set_in(0, 1, 0, 0, 0); #2;
            chk("a.w0_acs", int'(acs_en), 1);
            chk("a.w0_wr", int'(wr_addr), k);
            chk("a.w0_tbs", int'(tb_start), 0);
            tick();
        end
        set_in(0, 1, 0, 0, 0); #2;
        chk("a.w0_tb_start", int'(tb_start), 1);
        chk("a.w0_tb_flush", int'(tb_flush), 0);
        chk("a.w0_tb_addr", int'(tb_addr), 14);
        chk("a.w0_tb_len", int'(tb_len), 15);
        chk("a.w0_ready", int'(sym_ready), 0);
        chk("a.w0_acs_excl", int'(acs_en), 0);
        tick();
        for (int k = 0; k < TBL; k++) begin
            set_in(0, 1, 0, 0, 0); #2;
            chk("a.w1_ready", int'(sym_ready), 1);
            chk("a.w1_wr", int'(wr_addr), TBL + k);
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            set_in(0, 1, 0, 1, 0); #2;
            chk("a.stall_ready", int'(sym_ready), 0);
            chk("a.stall_tbs", int'(tb_start), 0);
            tick();
        end
        set_in(0, 1, 0, 0, 0); #2;
        chk("a.w1_tb_start", int'(tb_start), 1);
        chk("a.w1_tb_addr", int'(tb_addr), 29);
        chk("a.w1_tb_len", int'(tb_len), 15);
        tick();
        for (int k = 0; k < 10; k++) begin
            set_in(0, 1, (k == 9), 0, 0); #2;
            chk("a.w2_wr", int'(wr_addr), k);
            tick();
        end
        set_in(0, 0, 0, 0, 0); #2;
        chk("a.flush_tbs", int'(tb_start), 1);
        chk("a.flush_fl", int'(tb_flush), 1);
        chk("a.flush_tb_addr", int'(tb_addr), 9);
        chk("a.flush_tb_len", int'(tb_len), 10);
        tick();
        for (int j = 0; j < 3; j++) begin
            set_in(0, 0, 0, 0, 0); #2;
            chk("a.drain_fd", int'(frame_done), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 1); #2; chk("a.done_in_fd", int'(frame_done), 0); tick();
        set_in(0, 0, 0, 0, 0); #2; chk("a.frame_done", int'(frame_done), 1); tick();
        #2; chk("a.frame_done_1cyc", int'(frame_done), 0); tick();

        // Last symbol coincides with a full window: single flush traceback.
        start_frame("b");
        for (int k = 0; k < TBL; k++) begin
            set_in(0, 1, (k == TBL - 1), 0, 0); #2;
            chk("b.no_tbs", int'(tb_start), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0); #2;
        chk("b.tbs", int'(tb_start), 1);
        chk("b.fl", int'(tb_flush), 1);
        chk("b.tb_len", int'(tb_len), 15);
        chk("b.tb_addr", int'(tb_addr), 14);
        tick();
        #2; chk("b.single_tbs", int'(tb_start), 0);
        chk("b.ready_drain", int'(sym_ready), 0);
        set_in(0, 0, 0, 0, 1); tick();
        set_in(0, 0, 0, 0, 0); #2; chk("b.frame_done", int'(frame_done), 1); tick();

        // Reset during TB_REQ abandons the frame.
        start_frame("c");
        for (int k = 0; k < TBL; k++) begin
            set_in(0, 1, 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0, 0); #2;
        chk("c.tbs_pre", int'(tb_start), 1);
        rst_n = 1'b0; #1;
        chk_out("c.async_rst", e0);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_in(0, 1, 0, 0, 1); #2;
            chk_out("c.post_rst", e0);
            tick();
        end
        start_frame("c2");

        // Randomized traffic against the reference model.
        rst_n = 1'b0; tick();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0));
            if (!rst_n) m_reset();
            #2;
            chk_out($sformatf("rnd%0d", cyc), m_expect());
            @(posedge clk);
            if (rst_n) m_clock(frame_start, sym_valid, sym_last, tbu_busy, tbu_done);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
